// File: rtl/dshot_pkg.sv
// Shared DShot definitions for the receive decoder and the transmit-side divider.
// Holds the baud-to-cycle lookup, frame layout and the receiver state encoding.
package dshot_pkg;

  // System clock feeding both the transmitter divider and the receiver counters
  localparam int unsigned SYS_CLK_HZ = 12_000_000;

  // Frame layout: throttle [15:5], telemetry [4], crc [3:0]
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned THR_MSB    = 15;
  localparam int unsigned THR_LSB    = 5;
  localparam int unsigned TEL_BIT    = 4;
  localparam int unsigned CRC_MSB    = 3;
  localparam int unsigned CRC_LSB    = 0;
  localparam int unsigned CRC_DATA_W = 12;

  // Receiver states: waiting for a frame, measuring a bit high time, measuring the low gap
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } dshot_state_e;

  // clk_in cycles per DShot bit; unsupported rates fall back to DShot150
  function automatic int unsigned baud_to_cycles(input int unsigned baud);
    int unsigned cycles;
    case (baud)
      600000:  cycles = SYS_CLK_HZ / 600000;
      300000:  cycles = SYS_CLK_HZ / 300000;
      default: cycles = SYS_CLK_HZ / 150000;
    endcase
    return cycles;
  endfunction

endpackage

// File: rtl/dshot_crc4.sv
// Combinational DShot 4-bit checksum of the 12-bit throttle+telemetry word.
// Shared with the transmit path so both sides agree on the nibble XOR.
module dshot_crc4
  import dshot_pkg::*;
(
  input  logic [CRC_DATA_W-1:0] i_data,
  output logic [3:0]            o_crc
);

  // XOR of the three nibbles equals (v ^ v>>4 ^ v>>8) & 4'hF
  always_comb begin
    o_crc = i_data[3:0] ^ i_data[7:4] ^ i_data[11:8];
  end

endmodule

// File: rtl/dshot_rx_decoder.sv
// DShot receive decoder: measures each bit's high time on a synchronized line,
// assembles 16-bit frames MSB-first, checks the CRC and strobes the result.
// Optional build macro DSHOT_BIDIR_EN selects bidirectional DShot (inverted line,
// inverted checksum); the default build is normal polarity.
module dshot_rx_decoder
  import dshot_pkg::*;
#(
  parameter int unsigned BAUD = 150000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        enable,
  input  logic        dshot_in,
  output logic [10:0] throttle_out,
  output logic        telemetry_out,
  output logic        frame_valid,
  output logic        crc_error,
  output logic        frame_abort,
  output logic        busy
);

  localparam int unsigned BIT_CYCLES = baud_to_cycles(BAUD);
  localparam int unsigned THRESH     = BIT_CYCLES >> 1;
  localparam int unsigned MIN_HIGH   = BIT_CYCLES >> 3;
  localparam int unsigned GAP_CYCLES = 2 * BIT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] CntBit    = CNT_W'(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CntThresh = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CntMin    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] CntGap    = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [4:0]       LastBit   = 5'(FRAME_BITS - 1);

`ifdef DSHOT_BIDIR_EN
  // Bidirectional lines idle high; start the synchronizer there to avoid a false edge
  localparam logic LineIdle = 1'b1;
`else
  localparam logic LineIdle = 1'b0;
`endif

  logic                  r_sync1, r_sync2;
  logic                  w_line;
  logic                  r_line_q;
  logic                  r_rise, r_fall;

  dshot_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic                  w_eof, w_abort;

  logic [3:0]            w_crc_calc, w_crc_exp;
  logic                  w_crc_ok;

  logic [10:0]           r_throttle;
  logic                  r_telemetry;
  logic                  r_valid, r_crc_err, r_abort;

  // Two-flop synchronizer on the asynchronous DShot line
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sync1 <= LineIdle;
      r_sync2 <= LineIdle;
    end else begin
      r_sync1 <= dshot_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DSHOT_BIDIR_EN
  assign w_line = ~r_sync2;
`else
  assign w_line = r_sync2;
`endif

  // Registered edge detector; rise and fall share the pipeline so high times are exact
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_line_q <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_line_q <= w_line;
      r_rise   <= w_line & ~r_line_q;
      r_fall   <= ~w_line & r_line_q;
    end
  end

  // Saturating increment; the value counts the current cycle, so it is the elapsed length
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

  // Checksum of the frame as it will look after this cycle's shift
  dshot_crc4 u_crc (
    .i_data (w_shift_nxt[THR_MSB:TEL_BIT]),
    .o_crc  (w_crc_calc)
  );

`ifdef DSHOT_BIDIR_EN
  assign w_crc_exp = ~w_crc_calc;
`else
  assign w_crc_exp = w_crc_calc;
`endif

  assign w_crc_ok = (w_crc_exp == w_shift_nxt[CRC_MSB:CRC_LSB]);

  // Next-state logic: bit timing, frame assembly and abort detection
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_eof         = 1'b0;
    w_abort       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (r_rise) begin
          w_state_nxt   = StHigh;
          w_bit_cnt_nxt = '0;
        end
      end
      StHigh: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc >= CntBit) begin
          // Stuck high: wins even if the falling edge lands on the same cycle
          w_abort     = 1'b1;
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (r_fall) begin
          w_cnt_nxt = '0;
          if (w_cnt_inc < CntMin) begin
            w_abort     = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_shift_nxt   = {r_shift[FRAME_BITS-2:0], (w_cnt_inc >= CntThresh)};
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            if (r_bit_cnt == LastBit) begin
              w_eof       = 1'b1;
              w_state_nxt = StIdle;
            end else begin
              w_state_nxt = StLow;
            end
          end
        end
      end
      StLow: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_rise) begin
          w_state_nxt = StHigh;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= CntGap) begin
          w_abort     = 1'b1;
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and shift register; enable low parks the decoder in idle
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!enable) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Result registers and one-cycle strobes; only one strobe source can fire per cycle
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_throttle  <= '0;
      r_telemetry <= 1'b0;
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_abort     <= 1'b0;
    end else if (!enable) begin
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_valid   <= w_eof & w_crc_ok;
      r_crc_err <= w_eof & ~w_crc_ok;
      r_abort   <= w_abort;
      if (w_eof && w_crc_ok) begin
        r_throttle  <= w_shift_nxt[THR_MSB:THR_LSB];
        r_telemetry <= w_shift_nxt[TEL_BIT];
      end
    end
  end

  assign throttle_out  = r_throttle;
  assign telemetry_out = r_telemetry;
  assign frame_valid   = r_valid;
  assign crc_error     = r_crc_err;
  assign frame_abort   = r_abort;
  assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_dshot_rx_decoder.sv
// Self-checking bench for dshot_rx_decoder at DShot150 (80 cycles per bit).
// Table of frames with hand-computed results, plus gap, glitch, stuck-high,
// reset and enable sequences. Follows DSHOT_BIDIR_EN when it is defined.
module tb_dshot_rx_decoder;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        dshot_in;
  logic [10:0] throttle_out;
  logic        telemetry_out;
  logic        frame_valid;
  logic        crc_error;
  logic        frame_abort;
  logic        busy;

`ifdef DSHOT_BIDIR_EN
  localparam logic IdleLvl = 1'b1;
`else
  localparam logic IdleLvl = 1'b0;
`endif

  dshot_rx_decoder #(
    .BAUD (150000)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .enable        (enable),
    .dshot_in      (dshot_in),
    .throttle_out  (throttle_out),
    .telemetry_out (telemetry_out),
    .frame_valid   (frame_valid),
    .crc_error     (crc_error),
    .frame_abort   (frame_abort),
    .busy          (busy)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_crc    = 0;
  int n_abort  = 0;
  int n_multi  = 0;

  // Strobe counters, sampled away from the active edge
  always @(negedge clk_in) begin
    if (frame_valid) n_valid++;
    if (crc_error) n_crc++;
    if (frame_abort) n_abort++;
    if ((int'(frame_valid) + int'(crc_error) + int'(frame_abort)) > 1) n_multi++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Logical level; the physical line is inverted in bidirectional builds
  task automatic drive(input logic lvl);
    dshot_in = lvl ^ IdleLvl;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1);
    tick(b ? 60 : 30);
    drive(1'b0);
    tick(b ? 20 : 50);
  endtask

  task automatic send_bits(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[15-i]);
  endtask

  // Full frame with exact 4-cycle latency and one-cycle pulse checks on the last bit
  task automatic send_frame_chk(input string name, input logic [15:0] f, input logic ok,
                                input int exp_thr, input int exp_tel);
    int v0, c0, a0;
    v0 = n_valid;
    c0 = n_crc;
    a0 = n_abort;
    send_bits(f, 15);
    drive(1'b1);
    tick(f[0] ? 60 : 30);
    drive(1'b0);
    tick(3);
    check({name, "_early"}, int'({frame_valid, crc_error, frame_abort}), 0);
    tick(1);
    check({name, "_valid"}, int'(frame_valid), int'(ok));
    check({name, "_crcerr"}, int'(crc_error), int'(!ok));
    check({name, "_throttle"}, int'(throttle_out), exp_thr);
    check({name, "_telem"}, int'(telemetry_out), exp_tel);
    tick(1);
    check({name, "_pulse_end"}, int'({frame_valid, crc_error}), 0);
    check({name, "_busy"}, int'(busy), 0);
    tick(f[0] ? 15 : 45);
    check({name, "_nvalid"}, n_valid - v0, int'(ok));
    check({name, "_ncrc"}, n_crc - c0, int'(!ok));
    check({name, "_nabort"}, n_abort - a0, 0);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic        ok;
    int          thr;
    int          tel;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] good;
  int          v0, c0, a0;

  initial begin
`ifdef DSHOT_BIDIR_EN
    vecs[0] = '{16'h82C9, 1'b1, 1046, 0};
    vecs[1] = '{16'h82C6, 1'b0, 1046, 0};
    vecs[2] = '{16'h000F, 1'b1, 0, 0};
    vecs[3] = '{16'h123F, 1'b1, 145, 1};
    vecs[4] = '{16'hFFF0, 1'b1, 2047, 1};
    good    = 16'h82C9;
`else
    vecs[0] = '{16'h82C6, 1'b1, 1046, 0};
    vecs[1] = '{16'h82C7, 1'b0, 1046, 0};
    vecs[2] = '{16'h0000, 1'b1, 0, 0};
    vecs[3] = '{16'h1230, 1'b1, 145, 1};
    vecs[4] = '{16'hFFFF, 1'b1, 2047, 1};
    good    = 16'h82C6;
`endif

    reset  = 1'b1;
    enable = 1'b1;
    drive(1'b0);
    tick(3);
    check("rst_throttle", int'(throttle_out), 0);
    check("rst_outputs", int'({telemetry_out, frame_valid, crc_error, frame_abort, busy}), 0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 5; i++) begin
      send_frame_chk($sformatf("vec%0d", i), vecs[i].frame, vecs[i].ok, vecs[i].thr,
                     vecs[i].tel);
    end

    // Gap abort: 8 bits then a long low; abort only once the low reaches the gap
    send_frame_chk("pre_gap", good, 1'b1, 1046, 0);
    a0 = n_abort;
    v0 = n_valid;
    c0 = n_crc;
    send_bits(good, 8);
    tick(100);
    check("gap_not_yet", n_abort - a0, 0);
    tick(100);
    check("gap_abort", n_abort - a0, 1);
    check("gap_no_valid", n_valid - v0, 0);
    check("gap_no_crc", n_crc - c0, 0);
    check("gap_busy", int'(busy), 0);
    send_frame_chk("post_gap", good, 1'b1, 1046, 0);

    // Glitch: 5-cycle high mid-frame
    a0 = n_abort;
    send_bits(good, 3);
    drive(1'b1);
    tick(5);
    drive(1'b0);
    tick(30);
    check("glitch_abort", n_abort - a0, 1);
    check("glitch_busy", int'(busy), 0);
    tick(200);

    // Stuck high: a full bit period of high time
    a0 = n_abort;
    v0 = n_valid;
    send_bits(good, 2);
    drive(1'b1);
    tick(80);
    drive(1'b0);
    tick(20);
    check("stuck_abort", n_abort - a0, 1);
    check("stuck_busy", int'(busy), 0);
    check("stuck_no_valid", n_valid - v0, 0);
    tick(200);

    // Enable low mid-frame: back to idle, outputs held, no strobe
    v0 = n_valid;
    c0 = n_crc;
    a0 = n_abort;
    send_bits(good, 5);
    enable = 1'b0;
    tick(1);
    check("en_busy", int'(busy), 0);
    check("en_hold_thr", int'(throttle_out), 1046);
    tick(200);
    enable = 1'b1;
    tick(5);
    check("en_no_strobe", (n_valid - v0) + (n_crc - c0) + (n_abort - a0), 0);
    send_frame_chk("post_en", good, 1'b1, 1046, 0);

    // Reset after bit 10: outputs clear next cycle, next frame decodes
    v0 = n_valid;
    c0 = n_crc;
    a0 = n_abort;
    send_bits(good, 10);
    reset = 1'b1;
    tick(1);
    check("rst_mid_thr", int'(throttle_out), 0);
    check("rst_mid_out", int'({telemetry_out, frame_valid, crc_error, frame_abort, busy}), 0);
    reset = 1'b0;
    tick(10);
    check("rst_mid_no_strobe", (n_valid - v0) + (n_crc - c0) + (n_abort - a0), 0);
    send_frame_chk("post_rst", good, 1'b1, 1046, 0);

    check("pulse_exclusive", n_multi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
